fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that owns the program counter.
- Drives the byte address into the combinational instruction ROM, which holds 128 words (512 bytes, word index = pc>>2), and registers the returned word into the IF/ID pipeline register for decode.
- Handles sequential fetch, decode stalls, branch/jump redirects from execute, illegal-op exceptions, interrupts, and a supervisor bit.

Parameters:
- RESET_ADDR, 32'd0, PC after reset (program selector entry).
- ILLOP_ADDR, 32'd4, vector for illegal op or illegal fetch.
- XADR_ADDR, 32'd8, interrupt vector.
- IMEM_BYTES, 32'd512, ROM size; a fetch at or above this address is illegal.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pc_o  out  32  fetch byte address to ROM; bit31 is forced to 0
- instr_i  in  32  ROM data for pc_o, combinational, same cycle
- stall_i  in  1  decode cannot accept; hold IF/ID and PC
- redirect_valid_i  in  1  taken branch/JMP from execute
- redirect_target_i  in  32  target; bit31 is the requested supervisor bit
- exc_i  in  1  decode flagged the IF/ID instruction illegal
- irq_i  in  1  level interrupt request
- if_valid_o  out  1  IF/ID holds a real instruction
- if_instr_o  out  32  IF/ID instruction
- if_pc_plus4_o  out  32  address of the IF/ID instruction + 4
- xp_o  out  32  exception return address, for r30
- kernel_o  out  1  supervisor bit

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_ADDR, kernel_o = 1, state = BOOT.
  - if_valid_o = 0, if_instr_o = 0, if_pc_plus4_o = 0, xp_o = 0.
- States: BOOT, RUN.
  - BOOT lasts exactly one cycle after reset release. No fetch is latched (if_valid_o stays 0), pc holds, then go to RUN.
  - All events below are evaluated only in RUN.
- Latency: instr_i sampled for pc_o appears on if_instr_o one clock later.
- Per-cycle next-state priority (highest first):
  1. exc_i:
     - pc <= ILLOP_ADDR; xp_o <= if_pc_plus4_o; kernel_o <= 1; if_valid_o <= 0.
     - Applies even when stall_i=1.
  2. redirect_valid_i:
     - pc <= {1'b0, target[30:2], 2'b00}; if_valid_o <= 0 (squash the wrong-path fetch).
     - kernel_o <= kernel_o & target[31]: the bit can only be cleared, never set, by a redirect.
     - Applies even when stall_i=1.
  3. irq_i & ~kernel_o & ~stall_i:
     - pc <= XADR_ADDR; xp_o <= pc_o + 4; kernel_o <= 1; if_valid_o <= 0.
     - The instruction at pc_o is not executed; re-execution returns via xp_o-4.
  4. stall_i: pc, IF/ID and xp_o all hold.
  5. Illegal fetch (pc_o >= IMEM_BYTES or pc_o[1:0] != 0):
     - pc <= ILLOP_ADDR; xp_o <= pc_o + 4; kernel_o <= 1; if_valid_o <= 0.
  6. Sequential:
     - if_instr_o <= instr_i; if_pc_plus4_o <= pc_o + 4; if_valid_o <= 1; pc <= pc_o + 4.
- Arithmetic: all address adds are 32-bit modulo 2^32; wrap beyond IMEM_BYTES is caught by rule 5.
- Simultaneous exc_i and redirect_valid_i: exc_i wins; the redirect is dropped.
- irq_i while kernel_o=1 is ignored (level; it is taken once kernel_o clears).
- Reset asserted mid-stall or mid-redirect: immediate return to reset values; nothing is retained.
- A self-jump (redirect target equals the current pc) is legal; each occurrence squashes one fetch.

Decomposition:
- Shared package risc_fetch_pkg:
  - vector address constants RESET/ILLOP/XADR;
  - IMEM_BYTES;
  - state enum {BOOT, RUN};
  - next-PC select enum {SEL_EXC, SEL_REDIR, SEL_IRQ, SEL_HOLD, SEL_ILLFETCH, SEL_SEQ}.
- One sub-module, fetch_pc_sel: purely combinational priority encoder producing the select code and next pc. The registers stay in fetch_stage.

Test Plan:
- Reset release, no stall, ROM returns pc-derived words:
  - cycle 1 (BOOT): if_valid_o=0, pc_o=0.
  - then pc_o = 0, 4, 8; if_instr_o follows one cycle later; if_pc_plus4_o = 4, 8, 12.
- stall_i high 3 cycles at pc_o=12:
  - pc_o stays 12 and IF/ID holds word@8 throughout.
  - after release, the next latch is word@12 with if_pc_plus4_o=16.
- redirect_valid_i with target 0x80000050 while kernel_o=1:
  - next pc_o=0x50, if_valid_o=0 for one cycle, kernel_o stays 1.
  - a later redirect to 0x00000050 clears kernel_o.
- User mode, pc_o=0xA4, irq_i=1:
  - pc_o -> 0x8, xp_o=0xA8, kernel_o=1.
  - with irq_i held high, no second interrupt is taken until kernel_o clears.
- exc_i together with redirect_valid_i and stall_i, if_pc_plus4_o=0x3C:
  - pc_o -> 0x4, xp_o=0x3C, if_valid_o=0.
- Sequential fetch reaches pc_o=0x200 (IMEM_BYTES):
  - pc_o -> 0x4, xp_o=0x204, kernel_o=1.
- Assert rst_n=0 mid-redirect:
  - all outputs return to reset values asynchronously.
  - BOOT repeats after release.

Source files
------------

// File: rtl/risc_fetch_pkg.sv
// Shared constants and enums for the instruction-fetch stage.
package risc_fetch_pkg;

    localparam logic [31:0] RESET_ADDR = 32'd0;
    localparam logic [31:0] ILLOP_ADDR = 32'd4;
    localparam logic [31:0] XADR_ADDR  = 32'd8;
    localparam logic [31:0] IMEM_BYTES = 32'd512;

    // Redirect targets and fetch addresses drop bit 31 (supervisor) and the byte offset.
    localparam logic [31:0] PC_MASK     = 32'h7fff_ffff;
    localparam logic [31:0] TARGET_MASK = 32'h7fff_fffc;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_REDIR,
        SEL_IRQ,
        SEL_HOLD,
        SEL_ILLFETCH,
        SEL_SEQ
    } pc_sel_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: ROM port, decode/execute controls, IF/ID outputs.
interface fetch_stage_if;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        exc_i;
    logic        irq_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_plus4_o;
    logic [31:0] xp_o;
    logic        kernel_o;

    modport master (
        output pc_o, if_valid_o, if_instr_o, if_pc_plus4_o, xp_o, kernel_o,
        input  instr_i, stall_i, redirect_valid_i, redirect_target_i, exc_i, irq_i
    );

    modport slave (
        input  pc_o, if_valid_o, if_instr_o, if_pc_plus4_o, xp_o, kernel_o,
        output instr_i, stall_i, redirect_valid_i, redirect_target_i, exc_i, irq_i
    );
endinterface

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC priority encoder for the fetch stage.
module fetch_pc_sel
    import risc_fetch_pkg::*;
#(
    parameter logic [31:0] ILLOP_ADDR_P = ILLOP_ADDR,
    parameter logic [31:0] XADR_ADDR_P  = XADR_ADDR,
    parameter logic [31:0] IMEM_BYTES_P = IMEM_BYTES
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc,
    input  logic        irq,
    input  logic        kernel,
    output pc_sel_t     sel,
    output logic [31:0] next_pc
);

    logic ill_fetch;

    assign ill_fetch = (pc >= IMEM_BYTES_P) || (pc[1:0] != 2'b00);

    always_comb begin
        sel     = SEL_SEQ;
        next_pc = pc + 32'd4;
        if (exc) begin
            sel     = SEL_EXC;
            next_pc = ILLOP_ADDR_P;
        end else if (redirect_valid) begin
            sel     = SEL_REDIR;
            next_pc = redirect_target & TARGET_MASK;
        end else if (irq && !kernel && !stall) begin
            sel     = SEL_IRQ;
            next_pc = XADR_ADDR_P;
        end else if (stall) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (ill_fetch) begin
            sel     = SEL_ILLFETCH;
            next_pc = ILLOP_ADDR_P;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, supervisor bit, exception return address and IF/ID register.
//
// state | meaning
// BOOT  | first cycle after reset release; nothing latched, pc holds
// RUN   | normal fetch; exceptions, redirects, interrupts and stalls evaluated
module fetch_stage
    import risc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR_P = RESET_ADDR,
    parameter logic [31:0] ILLOP_ADDR_P = ILLOP_ADDR,
    parameter logic [31:0] XADR_ADDR_P  = XADR_ADDR,
    parameter logic [31:0] IMEM_BYTES_P = IMEM_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master fi
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_out;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    pc_sel_t      sel;

    assign pc_out   = pc & PC_MASK;
    assign pc_plus4 = pc_out + 32'd4;
    assign fi.pc_o  = pc_out;

    fetch_pc_sel #(
        .ILLOP_ADDR_P (ILLOP_ADDR_P),
        .XADR_ADDR_P  (XADR_ADDR_P),
        .IMEM_BYTES_P (IMEM_BYTES_P)
    ) u_pc_sel (
        .pc              (pc_out),
        .stall           (fi.stall_i),
        .redirect_valid  (fi.redirect_valid_i),
        .redirect_target (fi.redirect_target_i),
        .exc             (fi.exc_i),
        .irq             (fi.irq_i),
        .kernel          (fi.kernel_o),
        .sel             (sel),
        .next_pc         (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= BOOT;
            pc               <= RESET_ADDR_P;
            fi.kernel_o      <= 1'b1;
            fi.if_valid_o    <= 1'b0;
            fi.if_instr_o    <= 32'd0;
            fi.if_pc_plus4_o <= 32'd0;
            fi.xp_o          <= 32'd0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    pc <= next_pc;
                    case (sel)
                        SEL_EXC: begin
                            fi.xp_o       <= fi.if_pc_plus4_o;
                            fi.kernel_o   <= 1'b1;
                            fi.if_valid_o <= 1'b0;
                        end
                        SEL_REDIR: begin
                            // A redirect may drop supervisor mode but never enter it.
                            fi.kernel_o   <= fi.kernel_o & fi.redirect_target_i[31];
                            fi.if_valid_o <= 1'b0;
                        end
                        SEL_IRQ, SEL_ILLFETCH: begin
                            fi.xp_o       <= pc_plus4;
                            fi.kernel_o   <= 1'b1;
                            fi.if_valid_o <= 1'b0;
                        end
                        SEL_HOLD: ;
                        default: begin
                            fi.if_instr_o    <= fi.instr_i;
                            fi.if_pc_plus4_o <= pc_plus4;
                            fi.if_valid_o    <= 1'b1;
                        end
                    endcase
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a rule-level model.
module tb_fetch_stage;
    import risc_fetch_pkg::*;

    logic clk;
    logic rst_n;
    fetch_stage_if fi ();

    logic [31:0] rom [0:127];
    assign fi.instr_i = rom[fi.pc_o[8:2]];

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fi    (fi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state, updated once per rising edge from the fetch rules.
    logic        m_run;
    logic [31:0] m_pc;
    logic        m_kernel;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_xp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pc = RESET_ADDR; m_kernel = 1; m_valid = 0;
        m_instr = 0; m_pc4 = 0; m_xp = 0;
    endtask

    task automatic model_clock();
        logic [31:0] cur;
        cur = {1'b0, m_pc[30:0]};
        if (!m_run) begin
            m_run = 1;
        end else if (fi.exc_i) begin
            m_xp = m_pc4; m_kernel = 1; m_valid = 0; m_pc = ILLOP_ADDR;
        end else if (fi.redirect_valid_i) begin
            m_kernel = m_kernel && fi.redirect_target_i[31];
            m_valid = 0;
            m_pc = {1'b0, fi.redirect_target_i[30:2], 2'b00};
        end else if (fi.irq_i && !m_kernel && !fi.stall_i) begin
            m_xp = cur + 4; m_kernel = 1; m_valid = 0; m_pc = XADR_ADDR;
        end else if (fi.stall_i) begin
            // everything holds
        end else if (cur >= IMEM_BYTES || cur[1:0] != 2'b00) begin
            m_xp = cur + 4; m_kernel = 1; m_valid = 0; m_pc = ILLOP_ADDR;
        end else begin
            m_instr = rom[cur[8:2]]; m_pc4 = cur + 4; m_valid = 1; m_pc = cur + 4;
        end
    endtask

    task automatic check_all();
        check("pc", fi.pc_o, {1'b0, m_pc[30:0]});
        check("if_valid", {31'd0, fi.if_valid_o}, {31'd0, m_valid});
        check("if_instr", fi.if_instr_o, m_instr);
        check("if_pc_plus4", fi.if_pc_plus4_o, m_pc4);
        check("xp", fi.xp_o, m_xp);
        check("kernel", {31'd0, fi.kernel_o}, {31'd0, m_kernel});
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic st, input logic rv, input logic [31:0] rt,
                          input logic ex, input logic iq);
        fi.stall_i = st; fi.redirect_valid_i = rv; fi.redirect_target_i = rt;
        fi.exc_i = ex; fi.irq_i = iq;
    endtask

    task automatic check_reset_values();
        check("rst_pc", fi.pc_o, RESET_ADDR);
        check("rst_valid", {31'd0, fi.if_valid_o}, 32'd0);
        check("rst_instr", fi.if_instr_o, 32'd0);
        check("rst_pc4", fi.if_pc_plus4_o, 32'd0);
        check("rst_xp", fi.xp_o, 32'd0);
        check("rst_kernel", {31'd0, fi.kernel_o}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        set_in(0, 0, 0, 0, 0);
        rst_n = 0;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1;

        // BOOT cycle, then sequential fetch 0, 4, 8
        step();
        check("boot_valid", {31'd0, fi.if_valid_o}, 32'd0);
        check("boot_pc", fi.pc_o, 32'd0);
        repeat (3) step();
        check("seq_pc", fi.pc_o, 32'd12);
        check("seq_instr", fi.if_instr_o, rom[2]);
        check("seq_pc4", fi.if_pc_plus4_o, 32'd12);

        // three-cycle stall at pc 12
        set_in(1, 0, 0, 0, 0);
        repeat (3) step();
        check("stall_pc", fi.pc_o, 32'd12);
        check("stall_instr", fi.if_instr_o, rom[2]);
        set_in(0, 0, 0, 0, 0);
        step();
        check("unstall_instr", fi.if_instr_o, rom[3]);
        check("unstall_pc4", fi.if_pc_plus4_o, 32'd16);

        // redirect keeping kernel, then one that clears it
        set_in(0, 1, 32'h8000_0050, 0, 0);
        step();
        check("redir_pc", fi.pc_o, 32'h50);
        check("redir_valid", {31'd0, fi.if_valid_o}, 32'd0);
        check("redir_kernel", {31'd0, fi.kernel_o}, 32'd1);
        set_in(0, 0, 0, 0, 0);
        step();
        set_in(0, 1, 32'h0000_0050, 0, 0);
        step();
        check("redir_user", {31'd0, fi.kernel_o}, 32'd0);

        // interrupt in user mode at 0xA4
        set_in(0, 1, 32'h0000_00a4, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1);
        step();
        check("irq_pc", fi.pc_o, 32'h8);
        check("irq_xp", fi.xp_o, 32'ha8);
        check("irq_kernel", {31'd0, fi.kernel_o}, 32'd1);
        repeat (3) step();
        check("irq_masked_pc", fi.pc_o, 32'h14);
        set_in(0, 1, 32'h0000_0038, 0, 1);
        step();
        set_in(0, 0, 0, 0, 1);
        step();
        check("irq_again_pc", fi.pc_o, 32'h8);
        check("irq_again_xp", fi.xp_o, 32'h3c);

        // exception beats redirect and stall with if_pc_plus4 = 0x3C
        set_in(0, 1, 32'h0000_0038, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        step();
        check("pre_exc_pc4", fi.if_pc_plus4_o, 32'h3c);
        set_in(1, 1, 32'h0000_0100, 1, 0);
        step();
        check("exc_pc", fi.pc_o, 32'h4);
        check("exc_xp", fi.xp_o, 32'h3c);
        check("exc_valid", {31'd0, fi.if_valid_o}, 32'd0);

        // run off the end of the ROM
        set_in(0, 1, 32'h0000_01f8, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        repeat (2) step();
        check("edge_pc", fi.pc_o, 32'h200);
        step();
        check("illf_pc", fi.pc_o, 32'h4);
        check("illf_xp", fi.xp_o, 32'h204);
        check("illf_kernel", {31'd0, fi.kernel_o}, 32'd1);

        // async reset in the middle of a redirect
        set_in(0, 1, 32'h0000_0040, 0, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1;
        set_in(0, 0, 0, 0, 0);
        step();
        check("reboot_pc", fi.pc_o, 32'd0);
        step();
        check("reboot_seq_pc", fi.pc_o, 32'd4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom % 4) == 0, ($urandom % 6) == 0,
                   {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 'h27f))},
                   ($urandom % 12) == 0, ($urandom % 5) == 0);
            if (($urandom % 100) == 0) begin
                #2;
                rst_n = 0;
                model_reset();
                #1;
                check_reset_values();
                @(negedge clk);
                rst_n = 1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
